instr_encoder: RTL

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder.sv | 119 +++++++++++
 1 files changed

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - encodes MIPS-style instruction fields into 32-bit words
// and streams them into an instruction memory, one word per two cycles.
module instr_encoder #(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_mn,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_shamt,
    input  logic [5:0]        in_funct,
    input  logic [15:0]       in_imm,
    input  logic [25:0]       in_target,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              busy,
    output logic              full,
    output logic              err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_WRITE = 2'd2,
        ST_FULL  = 2'd3
    } state_t;

    state_t              state_q;
    logic [ADDR_W-1:0]   ptr_q;
    logic [ADDR_W:0]     count_q;
    logic                err_q;
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [31:0]         wdata_q;

    logic [31:0]         word_d;
    logic                legal_d;

    // Encoding is purely combinational; it is only captured on a legal accept.
    always_comb begin
        word_d  = 32'h0;
        legal_d = 1'b1;
        case (in_mn)
            4'd0:    word_d = {6'b000000, in_rs, in_rt, in_rd, in_shamt, in_funct};
            4'd1:    word_d = {6'b100011, in_rs, in_rt, in_imm};
            4'd2:    word_d = {6'b101011, in_rs, in_rt, in_imm};
            4'd3:    word_d = {6'b000010, in_target};
            4'd4:    word_d = {6'b001000, in_rs, in_rt, in_imm};
            4'd5:    word_d = {6'b001110, in_rs, in_rt, in_imm};
            4'd6:    word_d = {6'b000100, in_rs, in_rt, in_imm};
            4'd7:    word_d = {6'b001010, in_rs, in_rt, in_imm};
            4'd8:    word_d = {6'b000011, in_target};
            default: legal_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'h0;
        end else begin
            we_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_FULL: begin
                    if (start) begin
                        ptr_q   <= '0;
                        count_q <= '0;
                        err_q   <= 1'b0;
                        state_q <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (stop) begin
                        state_q <= ST_IDLE;
                    end else if (in_valid) begin
                        if (legal_d) begin
                            we_q    <= 1'b1;
                            addr_q  <= ptr_q;
                            wdata_q <= word_d;
                            state_q <= ST_WRITE;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                ST_WRITE: begin
                    // ptr wraps to 0 on the last slot; FULL then holds until start.
                    ptr_q   <= ptr_q + 1'b1;
                    count_q <= count_q + 1'b1;
                    state_q <= (ptr_q == {ADDR_W{1'b1}}) ? ST_FULL : ST_LOAD;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == ST_LOAD);
    assign busy      = (state_q == ST_LOAD) || (state_q == ST_WRITE);
    assign full      = (state_q == ST_FULL);
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign count     = count_q;
    assign err       = err_q;

endmodule
